mtimer_unit: RTL and testbench
==============================

// Module: mtimer_unit
// PURPOSE
//  Machine timer/software-interrupt unit (CLINT-style) sitting directly upstream of the privilege block.
//  Owns the 64-bit mtime counter, mtimecmp and msip; drives the mtime bus and the timer/soft interrupt lines consumed by the priv unit.
//  Memory-mapped through a simple single-outstanding request/busy slave port.
// PARAMETERS
//  BASE_ADDR  32'hFFFF_FFE0  byte address of register window (32-byte aligned)
//  PRESCALE   16'd1          mtime tick divider; used only with MTIMER_PRESCALE_EN; legal 1..65535
// PORTS
//  CLK        in   1   core clock; all state on rising edge
//  nRST       in   1   asynchronous, active-low reset
//  ren        in   1   bus read request
//  wen        in   1   bus write request (ren&wen both high = error)
//  addr       in   32  byte address
//  wdata      in   32  write data
//  byte_en    in   4   write byte lanes
//  rdata      out  32  read data, valid when busy=0 in response cycle
//  busy       out  1   high while request not yet completed
//  error      out  1   response-cycle error flag
//  mtime      out  64  current machine time
//  timer_int  out  1   machine timer interrupt pending
//  soft_int   out  1   machine software interrupt pending (msip[0])
// BEHAVIOUR
//  Reset: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, timer_int=0, soft_int=0, rdata=0, error=0, FSM=IDLE.
//  Register map (offset): 0x00 msip (bit0 only, rest RAZ/WI); 0x08 mtimecmp[31:0]; 0x0C mtimecmp[63:32];
//   0x10 mtime[31:0]; 0x14 mtime[63:32]; other offsets in window and addr outside window -> error.
//  addr[1:0]!=0 -> error. On error: no state change, rdata=0.
//  FSM IDLE/RESP: IDLE & (ren|wen) -> latch addr/op/wdata/byte_en, perform write or sample read, go RESP.
//   RESP: busy=0, rdata/error valid one cycle, return to IDLE unconditionally.
//  busy = (ren|wen) & (state==IDLE). Latency: request accepted cycle N, completes cycle N+1.
//   Master holding request in N+2 starts a new transaction; requests dropped in IDLE are ignored.
//  Read data is the register value at accept cycle N (registered into rdata).
//  Writes honour byte_en per lane; byte_en=0 is a legal no-op write.
//  mtime: increments by 1 per tick, full 64-bit carry, wraps 2^64-1 -> 0.
//   Bus write to either mtime half wins over tick in same cycle (written value stored, no increment that cycle).
//  timer_int registered: = (mtime >= mtimecmp) evaluated on current-cycle values; asserts 1 cycle after compare true;
//   clears 1 cycle after mtimecmp write raises cmp above mtime. Unsigned 64-bit compare.
//  soft_int = msip[0] register output directly; set/clear by write to 0x00 takes effect in RESP cycle.
//  Reset asserted mid-transaction: transaction aborted, all state to reset values, no partial write.
// CONFIGURATION
//  MTIMER_PRESCALE_EN defined: 16-bit prescale counter counts 0..PRESCALE-1; tick when counter==PRESCALE-1, then wraps to 0;
//   counter resets to 0 and also clears on any mtime write.
//  MTIMER_PRESCALE_EN undefined: tick every cycle; PRESCALE ignored; no prescale counter synthesised.
// TESTING
//  Reset release, idle 10 cycles -> mtime=10 (no prescale), timer_int=0, soft_int=0.
//  Write 0x08=32'd20, 0x0C=0 -> timer_int rises exactly 1 cycle after mtime==20; write 0x0C=1 -> clears next cycle.
//  Write 0x10=32'hFFFF_FFFF, 0x14=0 -> next tick mtime=64'h1_0000_0000; read 0x14 returns 1.
//  Write 0x00 wdata=1 byte_en=4'b0001 -> soft_int=1; byte_en=0 write of 0 -> soft_int stays 1.
//  Read addr BASE+0x04, BASE+0x09, ren&wen together -> error=1, rdata=0, no register change, busy low at N+1.
//  With MTIMER_PRESCALE_EN, PRESCALE=4: 40 cycles after reset -> mtime=10; mtime write resets phase.

Source files
------------

// File: rtl/mtimer_unit.sv
// mtimer_unit: CLINT-style machine timer / software interrupt unit.
// Owns mtime, mtimecmp and msip behind a single-outstanding request/busy slave.
// Optional feature macro: MTIMER_PRESCALE_EN (divides the mtime tick by PRESCALE).
module mtimer_unit #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FFE0,
    parameter logic [15:0] PRESCALE  = 16'd1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ren,
    input  logic        wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byte_en,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        error,
    output logic [63:0] mtime,
    output logic        timer_int,
    output logic        soft_int
);

    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic        timer_int_q, timer_int_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    logic        tick;
    logic        accept;
    logic        req_err;
    logic        do_write;
    logic        mtime_wr;
    logic        in_window;
    logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mt_lo, sel_mt_hi;
    logic [31:0] rd_val;

    // Byte-lane merge of write data into an existing 32-bit register value.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    // Address decode; misaligned offsets match no register and therefore error.
    always_comb begin
        in_window  = (addr[31:5] == BASE_ADDR[31:5]);
        sel_msip   = in_window && (addr[4:0] == 5'h00);
        sel_cmp_lo = in_window && (addr[4:0] == 5'h08);
        sel_cmp_hi = in_window && (addr[4:0] == 5'h0C);
        sel_mt_lo  = in_window && (addr[4:0] == 5'h10);
        sel_mt_hi  = in_window && (addr[4:0] == 5'h14);
        req_err    = (ren & wen) |
                     ~(sel_msip | sel_cmp_lo | sel_cmp_hi | sel_mt_lo | sel_mt_hi);
        accept     = (state_q == IDLE) & (ren | wen);
        do_write   = accept & wen & ~req_err;
        mtime_wr   = do_write & (sel_mt_lo | sel_mt_hi);
    end

    // Read mux, sampled at the accept edge.
    always_comb begin
        rd_val = '0;
        if (sel_msip)   rd_val = {31'd0, msip_q};
        if (sel_cmp_lo) rd_val = mtimecmp_q[31:0];
        if (sel_cmp_hi) rd_val = mtimecmp_q[63:32];
        if (sel_mt_lo)  rd_val = mtime_q[31:0];
        if (sel_mt_hi)  rd_val = mtime_q[63:32];
    end

`ifdef MTIMER_PRESCALE_EN
    logic [15:0] pre_cnt_q, pre_cnt_d;

    assign tick = (pre_cnt_q == (PRESCALE - 16'd1));

    // Prescale counter: wraps after PRESCALE-1, restarts the phase on any mtime write.
    always_comb begin
        pre_cnt_d = tick ? '0 : pre_cnt_q + 16'd1;
        if (mtime_wr) pre_cnt_d = '0;
    end

    // Prescale counter register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) pre_cnt_q <= '0;
        else       pre_cnt_q <= pre_cnt_d;
    end
`else
    // PRESCALE has no effect without the prescaler: mtime ticks every cycle.
    assign tick = 1'b1 | (PRESCALE == 16'd0);
`endif

    // Next-state: FSM, response capture, register writes and mtime tick.
    always_comb begin
        state_d     = state_q;
        mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d  = mtimecmp_q;
        msip_d      = msip_q;
        rdata_d     = '0;
        error_d     = 1'b0;
        timer_int_d = (mtime_q >= mtimecmp_q);

        case (state_q)
            IDLE: begin
                if (ren | wen) begin
                    state_d = RESP;
                    error_d = req_err;
                    if (ren & ~req_err) rdata_d = rd_val;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A bus write to either mtime half replaces that cycle's increment.
        if (do_write) begin
            if (sel_msip && byte_en[0]) msip_d = wdata[0];
            if (sel_cmp_lo) mtimecmp_d[31:0]  = lane_merge(mtimecmp_q[31:0], wdata, byte_en);
            if (sel_cmp_hi) mtimecmp_d[63:32] = lane_merge(mtimecmp_q[63:32], wdata, byte_en);
            if (sel_mt_lo)  mtime_d = {mtime_q[63:32], lane_merge(mtime_q[31:0], wdata, byte_en)};
            if (sel_mt_hi)  mtime_d = {lane_merge(mtime_q[63:32], wdata, byte_en), mtime_q[31:0]};
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            msip_q      <= 1'b0;
            timer_int_q <= 1'b0;
            rdata_q     <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            timer_int_q <= timer_int_d;
            rdata_q     <= rdata_d;
            error_q     <= error_d;
        end
    end

    assign busy      = accept;
    assign rdata     = rdata_q;
    assign error     = error_q;
    assign mtime     = mtime_q;
    assign timer_int = timer_int_q;
    assign soft_int  = msip_q;

endmodule

// File: tb/tb_mtimer_unit.sv
// tb_mtimer_unit: table-driven register checks plus hand-written timing sequences.
`timescale 1ns/1ps
module tb_mtimer_unit;

    localparam logic [31:0] BASE = 32'hFFFF_FFE0;
`ifdef MTIMER_PRESCALE_EN
    localparam int CYC = 4;
`else
    localparam int CYC = 1;
`endif

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ren = 1'b0, wen = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  byte_en = '0;
    logic [31:0] rdata;
    logic        busy, error, timer_int, soft_int;
    logic [63:0] mtime;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    mtimer_unit #(.BASE_ADDR(BASE), .PRESCALE(16'd4)) dut (
        .CLK(CLK), .nRST(nRST), .ren(ren), .wen(wen), .addr(addr), .wdata(wdata),
        .byte_en(byte_en), .rdata(rdata), .busy(busy), .error(error), .mtime(mtime),
        .timer_int(timer_int), .soft_int(soft_int)
    );

    typedef struct {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_soft;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus transaction, starting between edges in IDLE; returns the RESP-cycle view.
    task automatic txn(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be,
                       output logic [31:0] rd, output logic er, output logic tint,
                       output logic sint, output logic [63:0] mt);
        ren = r; wen = w; addr = a; wdata = d; byte_en = be;
        #1;
        check("busy_in_req", busy, 1'b1);
        @(posedge CLK); #1;
        check("busy_in_resp", busy, 1'b0);
        rd = rdata; er = error; tint = timer_int; sint = soft_int; mt = mtime;
        ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0; byte_en = '0;
        @(posedge CLK); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] rd; logic er, ti, si; logic [63:0] mt;
        txn(1'b0, 1'b1, a, d, be, rd, er, ti, si, mt);
        check("wr_err", er, 1'b0);
    endtask

    initial begin
        vec_t        tbl[24];
        logic [31:0] rd;
        logic        er, ti, si, found;
        logic [63:0] mt;

        tbl[0]  = '{1'b0, 1'b1, BASE + 32'h00, 32'h0000_0001, 4'b0001, 1'b0, 1'b0, 32'h0, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, BASE + 32'h00, 32'h0,         4'b0000, 1'b0, 1'b1, 32'h1, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, BASE + 32'h00, 32'h0,         4'b0000, 1'b0, 1'b0, 32'h0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, BASE + 32'h00, 32'h0,         4'b0000, 1'b0, 1'b1, 32'h1, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, BASE + 32'h00, 32'hFFFF_FFFE, 4'b1111, 1'b0, 1'b0, 32'h0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, BASE + 32'h00, 32'h0,         4'b0000, 1'b0, 1'b1, 32'h0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, BASE + 32'h00, 32'h0000_0001, 4'b0001, 1'b0, 1'b0, 32'h0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, BASE + 32'h08, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b0, 32'h0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, BASE + 32'h08, 32'h0,         4'b0000, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, BASE + 32'h08, 32'h0000_1234, 4'b0010, 1'b0, 1'b0, 32'h0, 1'b1};
        tbl[10] = '{1'b1, 1'b0, BASE + 32'h08, 32'h0,         4'b0000, 1'b0, 1'b1, 32'hDEAD_12EF, 1'b1};
        tbl[11] = '{1'b0, 1'b1, BASE + 32'h0C, 32'h0000_0001, 4'b1111, 1'b0, 1'b0, 32'h0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, BASE + 32'h0C, 32'h0,         4'b0000, 1'b0, 1'b1, 32'h1, 1'b1};
        tbl[13] = '{1'b1, 1'b0, BASE + 32'h04, 32'h0,         4'b0000, 1'b1, 1'b1, 32'h0, 1'b1};
        tbl[14] = '{1'b1, 1'b0, BASE + 32'h09, 32'h0,         4'b0000, 1'b1, 1'b1, 32'h0, 1'b1};
        tbl[15] = '{1'b1, 1'b0, BASE + 32'h1C, 32'h0,         4'b0000, 1'b1, 1'b1, 32'h0, 1'b1};
        tbl[16] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'b0000, 1'b1, 1'b1, 32'h0, 1'b1};
        tbl[17] = '{1'b0, 1'b1, BASE + 32'h04, 32'hFFFF_FFFF, 4'b1111, 1'b1, 1'b1, 32'h0, 1'b1};
        tbl[18] = '{1'b1, 1'b1, BASE + 32'h00, 32'h0,         4'b1111, 1'b1, 1'b1, 32'h0, 1'b1};
        tbl[19] = '{1'b1, 1'b0, BASE + 32'h00, 32'h0,         4'b0000, 1'b0, 1'b1, 32'h1, 1'b1};
        tbl[20] = '{1'b0, 1'b1, BASE + 32'h0A, 32'h0,         4'b1111, 1'b1, 1'b1, 32'h0, 1'b1};
        tbl[21] = '{1'b1, 1'b0, BASE + 32'h08, 32'h0,         4'b0000, 1'b0, 1'b1, 32'hDEAD_12EF, 1'b1};
        tbl[22] = '{1'b0, 1'b1, 32'h0000_0008, 32'h0,         4'b1111, 1'b1, 1'b1, 32'h0, 1'b1};
        tbl[23] = '{1'b1, 1'b0, BASE + 32'h08, 32'h0,         4'b0000, 1'b0, 1'b1, 32'hDEAD_12EF, 1'b1};

        // Reset values while nRST is held low.
        repeat (3) @(posedge CLK);
        #1;
        check("rst_mtime", mtime, 64'd0);
        check("rst_timer_int", timer_int, 1'b0);
        check("rst_soft_int", soft_int, 1'b0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_error", error, 1'b0);
        check("rst_busy", busy, 1'b0);

        // Ten ticks after release.
        nRST = 1'b1;
        repeat (10 * CYC) @(posedge CLK);
        #1;
        check("idle_mtime10", mtime, 64'd10);
        check("idle_timer_int", timer_int, 1'b0);
        check("idle_soft_int", soft_int, 1'b0);

        // Register access and error vectors.
        foreach (tbl[i]) begin
            txn(tbl[i].ren, tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].be, rd, er, ti, si, mt);
            check($sformatf("vec%0d_error", i), er, tbl[i].exp_err);
            if (tbl[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("vec%0d_soft", i), si, tbl[i].exp_soft);
        end

        // mtime write wins over the tick and restarts the tick phase.
        txn(1'b0, 1'b1, BASE + 32'h10, 32'h0, 4'b1111, rd, er, ti, si, mt);
        check("mt_wr_resp", mt, 64'd0);
        check("mt_wr_next", mtime, (CYC == 1) ? 64'd1 : 64'd0);
`ifdef MTIMER_PRESCALE_EN
        repeat (2) @(posedge CLK);
        #1;
        check("pre_phase_hold", mtime, 64'd0);
        @(posedge CLK); #1;
        check("pre_phase_tick", mtime, 64'd1);
`endif

        // Timer interrupt: rise one cycle after mtime reaches mtimecmp.
        wr(BASE + 32'h10, 32'd0, 4'b1111);
        wr(BASE + 32'h08, 32'd20, 4'b1111);
        wr(BASE + 32'h0C, 32'd0, 4'b1111);
        check("tint_before", timer_int, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 200 * CYC; i++) begin
            if (mtime == 64'd20) begin
                found = 1'b1;
                break;
            end
            @(posedge CLK); #1;
        end
        check("tint_reach20", found, 1'b1);
        check("tint_at_equal", timer_int, 1'b0);
        @(posedge CLK); #1;
        check("tint_rise", timer_int, 1'b1);

        // Raising mtimecmp clears the interrupt one cycle after the write lands.
        txn(1'b0, 1'b1, BASE + 32'h0C, 32'd1, 4'b1111, rd, er, ti, si, mt);
        check("tint_resp_still", ti, 1'b1);
        check("tint_cleared", timer_int, 1'b0);

        // Carry from low to high word.
        wr(BASE + 32'h14, 32'h0, 4'b1111);
        txn(1'b0, 1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'b1111, rd, er, ti, si, mt);
        check("carry_wr_resp", mt, 64'h0000_0000_FFFF_FFFF);
        for (int i = 0; i < 2 * CYC + 2; i++) begin
            if (mtime != 64'h0000_0000_FFFF_FFFF) break;
            @(posedge CLK); #1;
        end
        check("carry_mtime", mtime, 64'h0000_0001_0000_0000);
        txn(1'b1, 1'b0, BASE + 32'h14, 32'h0, 4'b0000, rd, er, ti, si, mt);
        check("carry_read_hi", rd, 32'h1);
        check("carry_read_err", er, 1'b0);

        // Full 64-bit wrap to zero.
        wr(BASE + 32'h14, 32'hFFFF_FFFF, 4'b1111);
        txn(1'b0, 1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'b1111, rd, er, ti, si, mt);
        check("wrap_wr_resp", mt, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 2 * CYC + 2; i++) begin
            if (mtime != 64'hFFFF_FFFF_FFFF_FFFF) break;
            @(posedge CLK); #1;
        end
        check("wrap_mtime", mtime, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
